// File: rtl/sobel_window_ctrl_if.sv
// Pixel-stream and line-buffer signal bundle for sobel_window_ctrl.
//   pix_valid_i / pix_data_i / pix_ready_o : upstream grey-pixel handshake
//   lb_rst_o / lb_we_o / lb_data_o          : commands to the double line buffer
//   lb_done_i                               : line buffer reports two lines stored
// master = controller side, slave = upstream source plus line buffer.
interface sobel_window_ctrl_if;
  logic       pix_valid_i;
  logic [7:0] pix_data_i;
  logic       pix_ready_o;
  logic       lb_rst_o;
  logic       lb_we_o;
  logic [7:0] lb_data_o;
  logic       lb_done_i;

  modport master (
    input  pix_valid_i, pix_data_i, lb_done_i,
    output pix_ready_o, lb_rst_o, lb_we_o, lb_data_o
  );

  modport slave (
    output pix_valid_i, pix_data_i, lb_done_i,
    input  pix_ready_o, lb_rst_o, lb_we_o, lb_data_o
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Frame controller feeding a double line buffer for a 3x3 Sobel window.
// A start request clears the line buffer for one cycle, then pixels are
// accepted in raster order and written to the line buffer one cycle later,
// together with their column/row and an interior-window flag.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : frame-start request (honoured only in IDLE)
//   bus           : pixel handshake and line-buffer signals (master side)
//   win_valid_o   : written pixel completes an interior 3x3 window
//   col_o, row_o  : coordinates of the pixel written this cycle
//   busy_o        : frame in progress
//   frame_done_o  : one-cycle pulse with the last write of the frame
//   err_o         : sticky, window claimed before line buffer was primed
module sobel_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10,
  parameter int RW    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  sobel_window_ctrl_if.master bus,
  output logic                win_valid_o,
  output logic [CW-1:0]       col_o,
  output logic [RW-1:0]       row_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                err_o
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  state_t        state_q, state_d;
  logic          ready_c, lb_rst_c, busy_c, done_c;
  logic          xfer_p0;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          vld_p1;
  logic [7:0]    data_p1;
  logic [CW-1:0] col_p1;
  logic [RW-1:0] row_p1;
  logic          win_p1;
  logic          err_q;
  logic          err_now;

  assign xfer_p0 = bus.pix_valid_i & ready_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    lb_rst_c = 1'b0;
    busy_c   = 1'b1;
    done_c   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        if (start_i) state_d = CLEAR;
      end
      CLEAR: begin
        lb_rst_c = 1'b1;
        state_d  = STREAM;
      end
      STREAM: begin
        ready_c = 1'b1;
        // Last pixel of the frame accepted: its write lands in DONE.
        if (bus.pix_valid_i && col_cnt == COL_LAST && row_cnt == ROW_LAST)
          state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0 -> p1: accept pixel, register write and its coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      col_p1  <= '0;
      row_p1  <= '0;
      win_p1  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == CLEAR) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (xfer_p0) begin
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      vld_p1 <= xfer_p0;
      win_p1 <= xfer_p0 && (col_cnt >= CW'(2)) && (row_cnt >= RW'(2));
      if (xfer_p0) begin
        data_p1 <= bus.pix_data_i;
        col_p1  <= col_cnt;
        row_p1  <= row_cnt;
      end
      if (err_now) err_q <= 1'b1;
    end
  end

  // The error is flagged in the same cycle as the offending window write,
  // then held by err_q.
  assign err_now = win_p1 & ~bus.lb_done_i;

  assign bus.pix_ready_o = ready_c;
  assign bus.lb_rst_o    = lb_rst_c;
  assign bus.lb_we_o     = vld_p1;
  assign bus.lb_data_o   = data_p1;
  assign win_valid_o     = win_p1;
  assign col_o           = col_p1;
  assign row_o           = row_p1;
  assign busy_o          = busy_c;
  assign frame_done_o    = done_c;
  assign err_o           = err_q | err_now;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
module tb_sobel_window_ctrl;
  localparam int IMG_W = 5;
  localparam int IMG_H = 3;
  localparam int CW    = 3;
  localparam int RW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          win_valid_o;
  logic [CW-1:0] col_o;
  logic [RW-1:0] row_o;
  logic          busy_o;
  logic          frame_done_o;
  logic          err_o;

  sobel_window_ctrl_if bus();

  sobel_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .RW(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .bus          (bus),
    .win_valid_o  (win_valid_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Line buffer model: reports primed once 10 pixels have been written since its clear.
  bit done_en;
  int wr_cnt;
  always @(posedge clk) begin
    if (rst || bus.lb_rst_o) wr_cnt <= 0;
    else if (bus.lb_we_o)    wr_cnt <= wr_cnt + 1;
  end
  assign bus.lb_done_i = done_en && (wr_cnt >= 10);

  // Recorder of line-buffer activity, sampled on the falling edge.
  logic [15:0] wq[$];
  int n_lbrst;
  int n_fdone;
  always @(negedge clk) begin
    if (bus.lb_rst_o) n_lbrst++;
    if (frame_done_o) n_fdone++;
    if (bus.lb_we_o)
      wq.push_back({bus.lb_data_o, col_o, row_o, win_valid_o, frame_done_o, err_o});
  end

  int n_assert;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rec_clear();
    wq.delete();
    n_lbrst = 0;
    n_fdone = 0;
  endtask

  task automatic send_frame(input bit gaps, input int stop, input bit start_in_stream,
                            input bit start_in_done);
    int  idx;
    bit  took;
    idx = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("clear_lbrst", 32'(bus.lb_rst_o), 32'd1);
    chk("clear_ready", 32'(bus.pix_ready_o), 32'd0);
    chk("clear_busy", 32'(busy_o), 32'd1);
    for (int cyc = 0; cyc < 200 && idx < stop; cyc++) begin
      bus.pix_valid_i = gaps ? cyc[0] : 1'b1;
      bus.pix_data_i  = 8'(idx);
      start_i = start_in_stream && (idx == 6);
      took = bus.pix_valid_i && bus.pix_ready_o;
      step();
      if (took) idx++;
    end
    start_i = 1'b0;
    bus.pix_valid_i = 1'b0;
    chk("feed_count", 32'(idx), 32'(stop));
    if (start_in_done) begin
      chk("in_done", 32'(frame_done_o), 32'd1);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int n, input int err_from, input int n_fd);
    logic [15:0] exp;
    chk({tag, "_lbrst"}, 32'(n_lbrst), 32'd1);
    chk({tag, "_nwr"}, 32'(wq.size()), 32'(n));
    chk({tag, "_nfdone"}, 32'(n_fdone), 32'(n_fd));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      exp = {8'(i), 3'(i % IMG_W), 2'(i / IMG_W), (i >= 12), (i == 14), (i >= err_from)};
      chk($sformatf("%s_wr%0d", tag, i), 32'(wq[i]), 32'(exp));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    done_en  = 1'b1;
    rst      = 1'b1;
    start_i  = 1'b0;
    bus.pix_valid_i = 1'b1;
    bus.pix_data_i  = 8'hA5;
    rec_clear();

    // Reset with a pixel on offer.
    step();
    step();
    chk("rst_ready", 32'(bus.pix_ready_o), 32'd0);
    chk("rst_lbrst", 32'(bus.lb_rst_o), 32'd0);
    chk("rst_we", 32'(bus.lb_we_o), 32'd0);
    chk("rst_data", 32'(bus.lb_data_o), 32'd0);
    chk("rst_win", 32'(win_valid_o), 32'd0);
    chk("rst_col", 32'(col_o), 32'd0);
    chk("rst_row", 32'(row_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_fdone", 32'(frame_done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);

    // Pixel offered in IDLE is not consumed.
    rst = 1'b0;
    step();
    step();
    chk("idle_ready", 32'(bus.pix_ready_o), 32'd0);
    chk("idle_we", 32'(bus.lb_we_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
    bus.pix_valid_i = 1'b0;
    chk("idle_nwr", 32'(wq.size()), 32'd0);

    // Full frame, back-to-back pixels.
    rec_clear();
    send_frame(1'b0, 15, 1'b0, 1'b0);
    idle(3);
    chk("full_busy_end", 32'(busy_o), 32'd0);
    check_frame("full", 15, 99, 1);
    chk("full_err", 32'(err_o), 32'd0);

    // Alternating valid gaps.
    rec_clear();
    send_frame(1'b1, 15, 1'b0, 1'b0);
    idle(3);
    check_frame("gaps", 15, 99, 1);

    // Line buffer never primed: error from the first window on, sticky until reset.
    done_en = 1'b0;
    rec_clear();
    send_frame(1'b0, 15, 1'b0, 1'b0);
    idle(5);
    check_frame("prime", 15, 12, 1);
    chk("prime_sticky", 32'(err_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("prime_rst_clears", 32'(err_o), 32'd0);
    done_en = 1'b1;
    step();

    // Reset mid-frame after pixel 7, with start and a pixel competing.
    rec_clear();
    send_frame(1'b0, 8, 1'b0, 1'b0);
    rst = 1'b1;
    start_i = 1'b1;
    bus.pix_valid_i = 1'b1;
    bus.pix_data_i  = 8'd8;
    step();
    chk("mid_busy", 32'(busy_o), 32'd0);
    chk("mid_we", 32'(bus.lb_we_o), 32'd0);
    chk("mid_ready", 32'(bus.pix_ready_o), 32'd0);
    rst = 1'b0;
    start_i = 1'b0;
    bus.pix_valid_i = 1'b0;
    idle(3);
    chk("mid_idle", 32'(busy_o), 32'd0);
    check_frame("mid", 8, 99, 0);

    rec_clear();
    send_frame(1'b0, 15, 1'b0, 1'b0);
    idle(3);
    check_frame("restart", 15, 99, 1);

    // start_i during STREAM and DONE is ignored.
    rec_clear();
    send_frame(1'b0, 15, 1'b1, 1'b1);
    chk("ign_after_done", 32'(busy_o), 32'd0);
    idle(3);
    chk("ign_idle", 32'(busy_o), 32'd0);
    check_frame("ign", 15, 99, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per line; must equal the line buffer DEPTH.
REQ-002 SHALL have parameter IMG_H, default 480, meaning lines per frame.
REQ-003 SHALL have parameter CW, default 10, meaning column counter width (2^CW > IMG_W).
REQ-004 SHALL have parameter RW, default 10, meaning row counter width (2^RW > IMG_H).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start_i  input  1  single-cycle frame-start request.
REQ-008 SHALL have port pix_valid_i  input  1  upstream pixel valid.
REQ-009 SHALL have port pix_data_i  input  8  upstream grey pixel.
REQ-010 SHALL have port pix_ready_o  output  1  controller accepts a pixel this cycle.
REQ-011 SHALL have port lb_rst_o  output  1  clear pulse to the double line buffer.
REQ-012 SHALL have port lb_we_o  output  1  line buffer write enable.
REQ-013 SHALL have port lb_data_o  output  8  line buffer write data.
REQ-014 SHALL have port lb_done_i  input  1  line buffer reports two lines stored.
REQ-015 SHALL have port win_valid_o  output  1  line buffer taps form a full interior 3x3 window this cycle.
REQ-016 SHALL have port col_o  output  CW  and row_o  output  RW: coordinates of the pixel written this cycle.
REQ-017 SHALL have port busy_o  output  1  high outside IDLE.
REQ-018 SHALL have port frame_done_o  output  1  single-cycle end-of-frame pulse.
REQ-019 SHALL have port err_o  output  1  sticky: window claimed before line buffer primed.

Function
REQ-020 SHALL implement FSM states IDLE, CLEAR, STREAM, DONE.
REQ-021 IDLE -> CLEAR on start_i; start_i in any other state SHALL be ignored.
REQ-022 CLEAR SHALL last exactly one cycle with lb_rst_o=1, zero col/row counters, then go to STREAM.
REQ-023 pix_ready_o SHALL be 1 only in STREAM; transfer = pix_valid_i & pix_ready_o; pixels offered in IDLE/CLEAR/DONE are not consumed.
REQ-024 On transfer, lb_we_o SHALL be 1 and lb_data_o = pix_data_i in the next cycle (1-cycle latency); otherwise lb_we_o=0, lb_data_o holds.
REQ-025 col/row counters SHALL advance on transfer only: col wraps IMG_W-1 -> 0 with row+1; col_o/row_o are registered alongside lb_we_o.
REQ-026 win_valid_o SHALL be registered with lb_we_o and equal 1 iff the written pixel has row>=2 and col>=2.
REQ-027 If win_valid_o=1 while lb_done_i=0, err_o SHALL set and hold until rst.
REQ-028 Transfer of pixel (IMG_W-1, IMG_H-1) SHALL move STREAM -> DONE; DONE lasts one cycle with frame_done_o=1 coinciding with the last lb_we_o, then IDLE.
REQ-029 start_i coincident with DONE SHALL be ignored; a new frame needs start_i in IDLE.
REQ-030 pix_valid_i gaps in STREAM SHALL stall counters with no writes and no timeout.
REQ-031 busy_o SHALL be 1 in CLEAR, STREAM, DONE.

Reset
REQ-032 rst=1 SHALL, in the same edge, force IDLE, counters 0, and all outputs 0 (pix_ready_o, lb_rst_o, lb_we_o, lb_data_o, win_valid_o, col_o, row_o, busy_o, frame_done_o, err_o).
REQ-033 rst mid-frame SHALL abandon the frame without frame_done_o; next frame restarts via start_i with a CLEAR cycle.
REQ-034 rst SHALL take priority over start_i and transfer in the same cycle.

Verification (IMG_W=5, IMG_H=3 unless stated)
REQ-035 Reset: rst high 2 cycles with pix_valid_i=1 -> all outputs 0, pix_ready_o=0.
REQ-036 Full frame: start_i, then pixels 0..14 back-to-back -> lb_rst_o one cycle, 15 lb_we_o pulses data 0..14, win_valid_o for data 12,13,14 only, frame_done_o with data 14, err_o=0 (lb_done_i model asserted after 10 writes).
REQ-037 Backpressure gaps: pix_valid_i toggled 1/0 -> 15 writes, order 0..14, col/row sequence unchanged, frame_done_o once.
REQ-038 Priming error: lb_done_i tied 0 -> err_o rises with data 12 write and stays 1 until rst.
REQ-039 Mid-frame reset: rst after pixel 7 -> IDLE, no frame_done_o; restart frame -> full REQ-036 response.
REQ-040 Ignored start: start_i pulsed during STREAM and in DONE -> no extra CLEAR; FSM returns to IDLE and waits.
